// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and constants for the button press decoder
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        LONG,
        REL_DB
    } btn_state_e;

    localparam int CNT_W     = 16;
    localparam int EVT_SHORT = 0;
    localparam int EVT_LONG  = 1;

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: 2-flop sync, ms-tick debounce, short/long/repeat classification
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 1000,
    parameter int REPEAT_MS     = 200
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_n_i,
    input  logic ms_tick_i,
    output logic level_o,
    output logic short_p_o,
    output logic long_p_o
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_MS - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_MS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MS - 1);

    logic [1:0]       sync_q;
    logic             btn_s;
    btn_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             long_f_q;
    logic             level_q;
    logic             short_p_q;
    logic             long_p_q;

    // Sync flops reset to the released (high) level so a held button is re-debounced.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], btn_n_i};
    end

    assign btn_s = ~sync_q[1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            long_f_q  <= 1'b0;
            level_q   <= 1'b0;
            short_p_q <= 1'b0;
            long_p_q  <= 1'b0;
        end else begin
            short_p_q <= 1'b0;
            long_p_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (btn_s) begin
                        state_q <= PRESS_DB;
                        cnt_q   <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!btn_s) begin
                        state_q <= IDLE;
                    end else if (ms_tick_i) begin
                        if (cnt_q == DB_LAST) begin
                            state_q <= HELD;
                            level_q <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state_q  <= REL_DB;
                        long_f_q <= 1'b0;
                        cnt_q    <= '0;
                    end else if (ms_tick_i) begin
                        if (cnt_q == LONG_LAST) begin
                            state_q  <= LONG;
                            long_p_q <= 1'b1;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                LONG: begin
                    if (!btn_s) begin
                        state_q  <= REL_DB;
                        long_f_q <= 1'b1;
                        cnt_q    <= '0;
                    end else if (ms_tick_i) begin
                        if (cnt_q == REP_LAST) begin
                            long_p_q <= 1'b1;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                REL_DB: begin
                    // A bounce back to pressed resumes the hold without emitting anything.
                    if (btn_s) begin
                        state_q <= long_f_q ? LONG : HELD;
                        cnt_q   <= '0;
                    end else if (ms_tick_i) begin
                        if (cnt_q == DB_LAST) begin
                            state_q   <= IDLE;
                            level_q   <= 1'b0;
                            short_p_q <= ~long_f_q;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign level_o   = level_q;
    assign short_p_o = short_p_q;
    assign long_p_o  = long_p_q;

endmodule

// File: rtl/btn_press_decoder.sv
// rtl/btn_press_decoder.sv - ms prescaler, per-button channels, sticky event flags and event counter
module btn_press_decoder
    import btn_pkg::*;
#(
    parameter int NUM_BTN       = 2,
    parameter int CLK_FREQ_HZ   = 27000000,
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 1000,
    parameter int REPEAT_MS     = 200
) (
    input  logic                 clk27,
    input  logic                 reset_n,
    input  logic [NUM_BTN-1:0]   btn_n_i,
    input  logic [2*NUM_BTN-1:0] event_ack_i,
    output logic [NUM_BTN-1:0]   btn_level_o,
    output logic [2*NUM_BTN-1:0] event_o,
    output logic [7:0]           event_cnt_o,
    output logic                 ms_tick_o
);

    localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
    localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (DEBOUNCE_MS < 1 || REPEAT_MS < 1 || LONG_PRESS_MS <= DEBOUNCE_MS || TICK_DIV < 1) begin : g_bad_params
        $error("btn_press_decoder: illegal timing parameters");
    end

    logic [PRESC_W-1:0]   presc_q;
    logic                 tick;
    logic [NUM_BTN-1:0]   short_p;
    logic [NUM_BTN-1:0]   long_p;
    logic [2*NUM_BTN-1:0] evt_set;
    logic [2*NUM_BTN-1:0] event_q, event_d;
    logic [7:0]           cnt_q, cnt_d;

    assign tick = (presc_q == PRESC_W'(TICK_DIV - 1));

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n)  presc_q <= '0;
        else if (tick) presc_q <= '0;
        else           presc_q <= presc_q + PRESC_W'(1);
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_MS  (DEBOUNCE_MS),
            .LONG_PRESS_MS(LONG_PRESS_MS),
            .REPEAT_MS    (REPEAT_MS)
        ) u_chan (
            .clk_i    (clk27),
            .rst_n_i  (reset_n),
            .btn_n_i  (btn_n_i[i]),
            .ms_tick_i(tick),
            .level_o  (btn_level_o[i]),
            .short_p_o(short_p[i]),
            .long_p_o (long_p[i])
        );
    end

    // Set has priority over a same-cycle acknowledge; counter adds the popcount of new pulses.
    always_comb begin
        evt_set = '0;
        cnt_d   = cnt_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            evt_set[2*i+EVT_SHORT] = short_p[i];
            evt_set[2*i+EVT_LONG]  = long_p[i];
        end
        for (int i = 0; i < 2*NUM_BTN; i++) begin
            cnt_d = cnt_d + 8'(evt_set[i]);
        end
        event_d = (event_q & ~event_ack_i) | evt_set;
    end

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            event_q <= '0;
            cnt_q   <= '0;
        end else begin
            event_q <= event_d;
            cnt_q   <= cnt_d;
        end
    end

    assign event_o     = event_q;
    assign event_cnt_o = cnt_q;
    assign ms_tick_o   = tick;

endmodule

// File: tb/tb_btn_press_decoder.sv
// tb/tb_btn_press_decoder.sv - self-checking bench for btn_press_decoder
module tb_btn_press_decoder;

    localparam int DB   = 4;
    localparam int LNG  = 50;
    localparam int REP  = 10;
    localparam int DIV  = 10;

    logic       clk27 = 1'b0;
    logic       reset_n;
    logic [1:0] btn_n_i;
    logic [3:0] event_ack_i;
    logic [1:0] btn_level_o;
    logic [3:0] event_o;
    logic [7:0] event_cnt_o;
    logic       ms_tick_o;

    int compared   = 0;
    int mismatched = 0;
    int cyc;
    logic [3:0] m_flags;
    int         m_cnt;

    btn_press_decoder #(
        .NUM_BTN      (2),
        .CLK_FREQ_HZ  (10000),
        .DEBOUNCE_MS  (DB),
        .LONG_PRESS_MS(LNG),
        .REPEAT_MS    (REP)
    ) dut (
        .clk27      (clk27),
        .reset_n    (reset_n),
        .btn_n_i    (btn_n_i),
        .event_ack_i(event_ack_i),
        .btn_level_o(btn_level_o),
        .event_o    (event_o),
        .event_cnt_o(event_cnt_o),
        .ms_tick_o  (ms_tick_o)
    );

    always #5 clk27 = ~clk27;

    // Cycles since reset release; ms boundaries fall on edges where cyc is a multiple of DIV.
    always @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk27);
            #1;
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic align();
        do step(1); while (cyc % DIV != 1);
    endtask

    task automatic do_reset();
        step(1);
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        m_flags = '0;
        m_cnt   = 0;
    endtask

    task automatic ack_all();
        event_ack_i = 4'hF;
        step(1);
        event_ack_i = 4'h0;
        m_flags = '0;
    endtask

    // Reference: a press spanning n whole ms is classified from n alone.
    function automatic int n_long(input int n);
        if (n < DB + LNG) return 0;
        return 1 + (n - DB - LNG) / REP;
    endfunction

    task automatic model_press(input int k, input int n);
        if (n >= DB) begin
            if (n_long(n) > 0) begin
                m_flags[2*k+1] = 1'b1;
                m_cnt += n_long(n);
            end else begin
                m_flags[2*k] = 1'b1;
                m_cnt += 1;
            end
            m_cnt = m_cnt % 256;
        end
    endtask

    task automatic press2(input int n0, input int n1);
        int nn[2];
        int nmax;
        nn[0] = n0;
        nn[1] = n1;
        nmax  = (n0 > n1) ? n0 : n1;
        ack_all();
        align();
        for (int k = 0; k < 2; k++) if (nn[k] > 0) btn_n_i[k] = 1'b0;
        for (int t = 1; t <= DIV * nmax; t++) begin
            step(1);
            for (int k = 0; k < 2; k++) begin
                if (nn[k] > DB + LNG && t == DIV * (DB + LNG) - 5)
                    check("long_pre", event_o[2*k+1], 1'b0);
                if (nn[k] > DB + LNG && t == DIV * (DB + LNG) + 5)
                    check("long_set", event_o[2*k+1], 1'b1);
                if (nn[k] > 0 && t == DIV * nn[k]) begin
                    check("hold_level", btn_level_o[k], nn[k] >= DB);
                    btn_n_i[k] = 1'b1;
                end
            end
        end
        step(6 * DIV);
        model_press(0, n0);
        model_press(1, n1);
        check("press_flags", event_o, m_flags);
        check("press_cnt", event_cnt_o, m_cnt);
        check("press_level", btn_level_o, 2'b00);
    endtask

    function automatic int rand_n();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return $urandom_range(1, 3);
            2:       return $urandom_range(4, 40);
            default: return $urandom_range(55, 90);
        endcase
    endfunction

    initial begin
        int rel;
        int a, b;
        reset_n     = 1'b0;
        btn_n_i     = 2'b11;
        event_ack_i = 4'h0;
        m_flags     = '0;
        m_cnt       = 0;
        step(3);
        check("rst_level", btn_level_o, 2'b00);
        check("rst_event", event_o, 4'h0);
        check("rst_cnt", event_cnt_o, 8'd0);
        check("rst_tick", ms_tick_o, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            step(1);
            check("ms_tick", ms_tick_o, (cyc % DIV) == DIV - 1);
        end
        check("idle_out", {btn_level_o, event_o, event_cnt_o}, 14'd0);

        align();
        btn_n_i[0] = 1'b0;
        step(25);
        check("glitch_level", btn_level_o[0], 1'b0);
        btn_n_i[0] = 1'b1;
        step(6 * DIV);
        check("glitch_event", event_o, 4'h0);
        check("glitch_cnt", event_cnt_o, 8'd0);

        press2(20, 0);
        press2(0, 100);

        ack_all();
        align();
        btn_n_i[0] = 1'b0;
        step(10 * DIV);
        for (int j = 0; j < 4; j++) begin
            btn_n_i[0] = ~btn_n_i[0];
            step(15);
            check("bounce_level", btn_level_o[0], 1'b1);
        end
        check("bounce_noevt", event_o, 4'h0);
        btn_n_i[0] = 1'b1;
        step(6 * DIV);
        model_press(0, DB);
        check("bounce_flags", event_o, m_flags);
        check("bounce_cnt", event_cnt_o, m_cnt);

        ack_all();
        align();
        btn_n_i[0] = 1'b0;
        step(6 * DIV);
        rel = cyc;
        btn_n_i[0] = 1'b1;
        wait_until(rel + DB * DIV - 1);
        event_ack_i = 4'b0001;
        step(1);
        event_ack_i = 4'b0000;
        check("set_wins", event_o[0], 1'b1);
        event_ack_i = 4'b0001;
        step(1);
        event_ack_i = 4'b0000;
        check("ack_clear", event_o[0], 1'b0);
        m_cnt = (m_cnt + 1) % 256;
        check("ack_cnt", event_cnt_o, m_cnt);

        for (int i = 0; i < 12; i++) begin
            a = rand_n();
            b = rand_n();
            if (a == 0 && b == 0) a = DB + 1;
            press2(a, b);
        end

        ack_all();
        align();
        btn_n_i[0] = 1'b0;
        step(8 * DIV);
        check("mid_held", btn_level_o[0], 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_level", btn_level_o, 2'b00);
        check("mid_rst_evt", {event_o, event_cnt_o}, 12'd0);
        step(3);
        reset_n = 1'b1;
        m_flags = '0;
        m_cnt   = 0;
        wait_until(35);
        check("redb_low", btn_level_o[0], 1'b0);
        wait_until(45);
        check("redb_high", btn_level_o[0], 1'b1);
        wait_until(61);
        btn_n_i[0] = 1'b1;
        step(6 * DIV);
        model_press(0, 6);
        check("redb_flags", event_o, m_flags);
        check("redb_cnt", event_cnt_o, m_cnt);

        do_reset();
        for (int i = 0; i < 256; i++) press2(DB + 1, 0);
        check("cnt_wrap", event_cnt_o, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
